// File: rtl/pll_scan_responder.sv
// pll_scan_responder
//   Behavioral stand-in for a reconfigurable PLL's scan interface. A reconfig
//   controller shifts a configuration image in serially. It then pulses
//   configupdate to apply the image. The block models the update latency and
//   the relock time that follows, and reports lock the way a real PLL would.
//
//   All scan-side inputs are treated as plain data. They are registered once
//   on input_clock, and edge detection runs on the registered copies.
//
// Ports
//   input_clock          single clock, rising edge
//   input_reset          synchronous, active-high
//   pll_scanclk          scan clock from the reconfig circuit (sampled)
//   pll_scanclkena       shift enable
//   pll_scandata         serial scan data in
//   pll_configupdate     request to apply the scan image (rising edge)
//   pll_areset           PLL reset, active-high
//   pll_scandataout      serial scan data out (chain MSB)
//   pll_scandone         update-complete flag, held until the next shift
//   locked               emulated PLL lock
//   active_config        applied configuration image
//   shift_count          accepted shifts since last update, saturates at 255
//   output_current_state IDLE=0, SHIFT=1, UPDATE=2, RELOCK=3
module pll_scan_responder #(
  parameter int                     SCAN_LEN      = 144,
  parameter int                     UPDATE_CYCLES = 4,
  parameter int                     LOCK_CYCLES   = 16,
  parameter logic [SCAN_LEN-1:0]    INIT_CONFIG   = '0
) (
  input  logic                input_clock,
  input  logic                input_reset,
  input  logic                pll_scanclk,
  input  logic                pll_scanclkena,
  input  logic                pll_scandata,
  input  logic                pll_configupdate,
  input  logic                pll_areset,
  output logic                pll_scandataout,
  output logic                pll_scandone,
  output logic                locked,
  output logic [SCAN_LEN-1:0] active_config,
  output logic [7:0]          shift_count,
  output logic [1:0]          output_current_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RELOCK = 2'd3
  } state_t;

  // Counter widths are sized so the terminal value (CYCLES-1) always fits.
  localparam int UCW = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES + 1) : 1;
  localparam int LCW = (LOCK_CYCLES > 1)   ? $clog2(LOCK_CYCLES + 1)   : 1;
  localparam logic [UCW-1:0] UPD_LAST  = UCW'(UPDATE_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  state_t              state, state_nx;
  logic [SCAN_LEN-1:0] shift_reg;
  logic [UCW-1:0]      upd_cnt;
  logic [LCW-1:0]      lock_cnt;

  // Registered scan inputs. The *_qq copies hold the previous registered
  // value and are used only for edge detection.
  logic sclk_q, sclk_qq, sena_q, sdata_q, cfg_q, cfg_qq;
  logic sclk_rise, cfg_rise;

  // Single-cycle control strobes decoded by the FSM.
  logic do_shift;    // accepted shift this cycle
  logic upd_enter;   // IDLE/SHIFT -> UPDATE
  logic upd_exit;    // normal UPDATE completion
  logic upd_abort;   // UPDATE cut short by pll_areset
  logic lock_done;   // RELOCK completed, lock acquired

  // ---------------------------------------------------------------------------
  // Input registration
  // ---------------------------------------------------------------------------
  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      sena_q  <= 1'b0;
      sdata_q <= 1'b0;
      cfg_q   <= 1'b0;
      cfg_qq  <= 1'b0;
    end else begin
      sclk_q  <= pll_scanclk;
      sclk_qq <= sclk_q;
      sena_q  <= pll_scanclkena;
      sdata_q <= pll_scandata;
      cfg_q   <= pll_configupdate;
      cfg_qq  <= cfg_q;
    end
  end

  assign sclk_rise = sclk_q & ~sclk_qq;
  assign cfg_rise  = cfg_q  & ~cfg_qq;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge input_clock) begin
    if (input_reset) state <= ST_RELOCK;
    else             state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    do_shift  = 1'b0;
    upd_enter = 1'b0;
    upd_exit  = 1'b0;
    upd_abort = 1'b0;
    lock_done = 1'b0;
    case (state)
      ST_IDLE, ST_SHIFT: begin
        if (pll_areset) begin
          // Losing the PLL does not block the scan chain. Only the update
          // request is discarded.
          state_nx = ST_RELOCK;
          do_shift = sclk_rise & sena_q;
        end else if (cfg_rise) begin
          // Update wins. A coincident shift is dropped so the image being
          // applied is exactly what was in the chain when the request arrived.
          state_nx  = ST_UPDATE;
          upd_enter = 1'b1;
        end else if (sclk_rise && sena_q) begin
          state_nx = ST_SHIFT;
          do_shift = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (pll_areset) begin
          state_nx  = ST_RELOCK;
          upd_abort = 1'b1;
        end else if (upd_cnt == UPD_LAST) begin
          state_nx = ST_RELOCK;
          upd_exit = 1'b1;
        end
      end
      ST_RELOCK: begin
        do_shift = sclk_rise & sena_q;
        if (!pll_areset && lock_cnt == LOCK_LAST) begin
          state_nx  = ST_IDLE;
          lock_done = 1'b1;
        end
      end
      default: state_nx = ST_RELOCK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Update-latency and relock counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      upd_cnt <= '0;
    end else if (upd_enter) begin
      upd_cnt <= '0;
    end else if (state == ST_UPDATE) begin
      upd_cnt <= upd_cnt + 1'b1;
    end
  end

  // The lock counter sits at zero outside RELOCK. Every entry into RELOCK
  // therefore starts a fresh count, and any areset pulse restarts it.
  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      lock_cnt <= '0;
    end else if (pll_areset || state != ST_RELOCK) begin
      lock_cnt <= '0;
    end else if (!lock_done) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan chain and applied image
  // ---------------------------------------------------------------------------
  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      shift_reg <= '0;
    end else if (do_shift) begin
      shift_reg <= {shift_reg[SCAN_LEN-2:0], sdata_q};
    end
  end

  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      active_config <= INIT_CONFIG;
    end else if (upd_exit) begin
      active_config <= shift_reg;
    end
  end

  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      shift_count <= '0;
    end else if (upd_exit) begin
      shift_count <= '0;
    end else if (do_shift && shift_count != 8'hFF) begin
      shift_count <= shift_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      pll_scandone <= 1'b0;
    end else if (upd_exit) begin
      pll_scandone <= 1'b1;
    end else if (do_shift || upd_abort) begin
      pll_scandone <= 1'b0;
    end
  end

  // Lock is only reported in IDLE/SHIFT. It drops as soon as an update
  // starts, so it is never seen high in UPDATE or RELOCK.
  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      locked <= 1'b0;
    end else if (pll_areset || upd_enter || upd_exit) begin
      locked <= 1'b0;
    end else if (lock_done) begin
      locked <= 1'b1;
    end
  end

  assign pll_scandataout      = shift_reg[SCAN_LEN-1];
  assign output_current_state = state;

endmodule

// File: tb/tb_pll_scan_responder.sv
// Bench for pll_scan_responder. The stimulus pushes the expected value for a
// named output into a scoreboard queue, tagged with the current cycle. A
// monitor branch pops and compares on the falling edge of that cycle.
module tb_pll_scan_responder;
  localparam int SL = 144;

  localparam int S_STATE = 0;
  localparam int S_LOCK  = 1;
  localparam int S_DONE  = 2;
  localparam int S_CNT   = 3;
  localparam int S_CFG   = 4;
  localparam int S_DOUT  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sclk, sena, sdata, cfg, areset;
  logic          dout, done, lck;
  logic [SL-1:0] act_cfg;
  logic [7:0]    cnt;
  logic [1:0]    st;

  pll_scan_responder dut (
    .input_clock          (clk),
    .input_reset          (rst),
    .pll_scanclk          (sclk),
    .pll_scanclkena       (sena),
    .pll_scandata         (sdata),
    .pll_configupdate     (cfg),
    .pll_areset           (areset),
    .pll_scandataout      (dout),
    .pll_scandone         (done),
    .locked               (lck),
    .active_config        (act_cfg),
    .shift_count          (cnt),
    .output_current_state (st)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            q_cyc[$];
  int            q_sig[$];
  logic [SL-1:0] q_val[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  logic [SL-1:0] pat;
  logic [SL-1:0] model_sr;

  function automatic logic [SL-1:0] actual(int s);
    logic [SL-1:0] r;
    r = '0;
    case (s)
      S_STATE: r[1:0] = st;
      S_LOCK:  r[0]   = lck;
      S_DONE:  r[0]   = done;
      S_CNT:   r[7:0] = cnt;
      S_CFG:   r      = act_cfg;
      default: r[0]   = dout;
    endcase
    return r;
  endfunction

  function automatic string sname(int s);
    case (s)
      S_STATE: return "state";
      S_LOCK:  return "locked";
      S_DONE:  return "scandone";
      S_CNT:   return "shift_count";
      S_CFG:   return "active_config";
      default: return "scandataout";
    endcase
  endfunction

  function automatic logic bitval(int j);
    return ((j * 5) % 7) > 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_v(int s, logic [SL-1:0] v);
    q_cyc.push_back(cyc);
    q_sig.push_back(s);
    q_val.push_back(v);
  endtask

  task automatic exp_i(int s, int v);
    exp_v(s, SL'(v));
  endtask

  // One scan clock pulse: two cycles high, two low.
  task automatic pulse(logic d, logic ena);
    sclk  = 1'b1;
    sdata = d;
    sena  = ena;
    tick();
    tick();
    sclk = 1'b0;
    tick();
    tick();
    if (ena) model_sr = {model_sr[SL-2:0], d};
  endtask

  // Raise configupdate and return once the block has entered UPDATE.
  task automatic cfg_update();
    cfg = 1'b1;
    tick();
    tick();
    cfg = 1'b0;
  endtask

  task automatic relock_check();
    repeat (15) tick();
    exp_i(S_STATE, 3);
    exp_i(S_LOCK, 0);
    tick();
    exp_i(S_STATE, 0);
    exp_i(S_LOCK, 1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
          int            s;
          logic [SL-1:0] v;
          logic [SL-1:0] a;
          void'(q_cyc.pop_front());
          s = q_sig.pop_front();
          v = q_val.pop_front();
          a = actual(s);
          n_cmp++;
          if (a !== v) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", sname(s), cyc, a, v);
          end
        end
      end
    join_none

    pat      = 144'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5C3;
    model_sr = '0;
    rst = 1'b1; sclk = 1'b0; sena = 1'b0; sdata = 1'b0; cfg = 1'b0; areset = 1'b0;
    repeat (3) tick();
    exp_i(S_STATE, 3);
    exp_i(S_LOCK, 0);
    exp_i(S_DONE, 0);
    exp_i(S_CNT, 0);
    exp_i(S_CFG, 0);

    // Release reset: lock after exactly 16 cycles.
    rst = 1'b0;
    relock_check();
    exp_i(S_DONE, 0);
    exp_i(S_CFG, 0);

    // Shift a full image and apply it.
    for (int i = SL - 1; i >= 0; i--) pulse(pat[i], 1'b1);
    exp_i(S_STATE, 1);
    exp_i(S_CNT, 144);
    exp_i(S_DOUT, int'(pat[SL-1]));
    cfg_update();
    exp_i(S_STATE, 2);
    repeat (3) tick();
    exp_i(S_STATE, 2);
    exp_i(S_DONE, 0);
    tick();
    exp_i(S_STATE, 3);
    exp_i(S_DONE, 1);
    exp_v(S_CFG, pat);
    exp_i(S_CNT, 0);
    exp_i(S_LOCK, 0);
    relock_check();

    // Pulses with the enable low are ignored.
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    exp_i(S_STATE, 0);
    exp_i(S_DONE, 1);
    exp_i(S_CNT, 0);

    // Overlength shifting: the chain MSB replays the early bits, and the
    // count saturates.
    for (int j = 1; j <= 300; j++) begin
      pulse(bitval(j), 1'b1);
      if (j == 1) begin
        exp_i(S_DONE, 0);
        exp_i(S_STATE, 1);
      end
      if (j >= 144 && j <= 149) exp_i(S_DOUT, int'(bitval(j - 143)));
      if (j == 150) exp_i(S_CNT, 150);
    end
    exp_i(S_CNT, 255);
    exp_i(S_STATE, 1);

    // areset during UPDATE aborts it and keeps the old image.
    cfg_update();
    exp_i(S_STATE, 2);
    tick();
    areset = 1'b1;
    tick();
    exp_i(S_STATE, 3);
    exp_v(S_CFG, pat);
    exp_i(S_DONE, 0);
    exp_i(S_LOCK, 0);
    repeat (2) tick();
    areset = 1'b0;
    relock_check();

    // The chain survives the abort, and a plain update applies it.
    cfg_update();
    repeat (4) tick();
    exp_i(S_STATE, 3);
    exp_v(S_CFG, model_sr);
    exp_i(S_DONE, 1);
    exp_i(S_CNT, 0);
    repeat (16) tick();

    // A shift coincident with configupdate is dropped. Rises during UPDATE
    // are ignored.
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    exp_i(S_CNT, 3);
    sclk = 1'b1; sena = 1'b1; sdata = ~model_sr[0]; cfg = 1'b1;
    tick();
    tick();
    exp_i(S_STATE, 2);
    exp_i(S_CNT, 3);
    cfg = 1'b0; sclk = 1'b0;
    tick();
    sclk = 1'b1;
    tick();
    sclk = 1'b0;
    tick();
    exp_i(S_STATE, 2);
    exp_i(S_CNT, 3);
    tick();
    exp_i(S_STATE, 3);
    exp_v(S_CFG, model_sr);
    exp_i(S_DONE, 1);
    relock_check();

    // Reset in the middle of UPDATE reverts to the initial image.
    cfg_update();
    tick();
    rst = 1'b1;
    tick();
    exp_i(S_STATE, 3);
    exp_i(S_CFG, 0);
    exp_i(S_CNT, 0);
    exp_i(S_LOCK, 0);
    exp_i(S_DONE, 0);
    rst = 1'b0;
    relock_check();
    exp_i(S_CFG, 0);

    for (int i = 0; i < 5 && q_cyc.size() > 0; i++) tick();
    if (q_cyc.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations pending, expected 0", q_cyc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
